sap_prog_loader: RTL and testbench

Program loader for the SAP-1 microprogrammed processor: accepts a stream of 9-bit words over a valid/ready handshake, writes them into the 16-location program/data SRAM via its write port, and validates a trailing checksum word. It sits directly upstream of the SRAM and holds the CPU in reset (`cpu_rst`) until a load completes with a good checksum, then releases it to run from address 0.

---
 rtl/sap_pkg.sv | 17 +
 rtl/sap_cksum_acc.sv | 34 +++
 rtl/sap_prog_loader.sv | 117 +++++++++++
 tb/tb_sap_prog_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 constants and the program loader state type.
// The widths are shared with the SRAM and the MAR.
package sap_pkg;

   localparam int DATA_W = 9;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      RUN   = 3'd3,
      ERR   = 3'd4
   } loader_state_e;

endpackage

// File: rtl/sap_cksum_acc.sv
// Modular checksum accumulator for the program loader.
// sum_zero reports whether adding check_word would bring the running sum to zero.
module sap_cksum_acc
   import sap_pkg::*;
#(
   parameter int DATA_W = sap_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              add_en,
   input  logic [DATA_W-1:0] add_data,
   input  logic [DATA_W-1:0] check_word,
   output logic              sum_zero
);

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] total;

   // Addition wraps naturally at the register width, giving the sum modulo 2^DATA_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= acc + add_data;
      end
   end

   assign total    = acc + check_word;
   assign sum_zero = (total == '0);

endmodule

// File: rtl/sap_prog_loader.sv
// SAP-1 program loader: streams DEPTH words into the program SRAM, validates a
// trailing checksum and holds the CPU in reset until a good load completes.
module sap_prog_loader
   import sap_pkg::*;
#(
   parameter int DATA_W = sap_pkg::DATA_W,
   parameter int ADDR_W = sap_pkg::ADDR_W,
   parameter int DEPTH  = sap_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] word_cnt
);

   localparam logic [2:0] ST_IDLE  = IDLE;
   localparam logic [2:0] ST_LOAD  = LOAD;
   localparam logic [2:0] ST_CHECK = CHECK;
   localparam logic [2:0] ST_RUN   = RUN;
   localparam logic [2:0] ST_ERR   = ERR;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] CNT_MAX  = ADDR_W'(DEPTH);

   logic [2:0] state;
   logic       xfer;
   logic       load_xfer;
   logic       check_xfer;
   logic       begin_load;
   logic       cksum_ok;

   // All status outputs decode the registered state, so none can glitch on inputs.
   assign in_ready   = (state == ST_LOAD) || (state == ST_CHECK);
   assign busy       = in_ready;
   assign done       = (state == ST_RUN);
   assign err        = (state == ST_ERR);
   assign cpu_rst    = (state != ST_RUN);

   assign xfer       = in_valid && in_ready;
   assign load_xfer  = xfer && (state == ST_LOAD);
   assign check_xfer = xfer && (state == ST_CHECK);
   assign begin_load = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));

   sap_cksum_acc #(
      .DATA_W(DATA_W)
   ) u_cksum (
      .clk       (clk),
      .rst       (rst),
      .clear     (begin_load),
      .add_en    (load_xfer),
      .add_data  (in_data),
      .check_word(in_data),
      .sum_zero  (cksum_ok)
   );

   // Leaving RUN on start reasserts cpu_rst on that same edge, so the CPU never runs mid-reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
               if (start) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (load_xfer && (word_cnt == LAST_IDX)) begin
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (check_xfer) begin
                  state <= cksum_ok ? ST_RUN : ST_ERR;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
      end else if (begin_load) begin
         word_cnt <= '0;
      end else if (load_xfer && (word_cnt != CNT_MAX)) begin
         word_cnt <= word_cnt + 1'b1;
      end
   end

   // One-cycle registered write pulse; address and data hold between writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= load_xfer;
         if (load_xfer) begin
            mem_addr  <= word_cnt;
            mem_wdata <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Randomized self-checking bench for sap_prog_loader against a cycle-level
// behavioural model of the load/check/run protocol.
module tb_sap_prog_loader;

   localparam int DW    = 9;
   localparam int AW    = 5;
   localparam int DEPTH = 16;
   localparam int MODV  = 1 << DW;

   localparam int PH_IDLE  = 0;
   localparam int PH_LOAD  = 1;
   localparam int PH_CHECK = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_ERR   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_rst;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] word_cnt;

   int checks_total  = 0;
   int checks_passed = 0;

   int ph;
   int m_cnt;
   int m_sum;
   int exp_we;
   int exp_addr;
   int exp_data;

   logic [DW-1:0] sram  [DEPTH];
   logic [DW-1:0] words [DEPTH];

   sap_prog_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_rst  (cpu_rst),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   // Stand-in for the program SRAM write port.
   always @(posedge clk) begin
      if (mem_we === 1'b1) sram[mem_addr[3:0]] <= mem_wdata;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks_total++;
      if (observed === expected) checks_passed++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   task automatic checkAll();
      checkOutput("mem_we",    32'(mem_we),    32'(exp_we));
      checkOutput("mem_addr",  32'(mem_addr),  32'(exp_addr));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(exp_data));
      checkOutput("in_ready",  32'(in_ready),  32'(ph == PH_LOAD || ph == PH_CHECK));
      checkOutput("busy",      32'(busy),      32'(ph == PH_LOAD || ph == PH_CHECK));
      checkOutput("cpu_rst",   32'(cpu_rst),   32'(ph != PH_RUN));
      checkOutput("done",      32'(done),      32'(ph == PH_RUN));
      checkOutput("err",       32'(err),       32'(ph == PH_ERR));
      checkOutput("word_cnt",  32'(word_cnt),  32'(m_cnt));
   endtask

   // Drives one cycle of inputs, advances the model by one edge, then checks.
   task automatic applyStimulus(input bit s, input bit v, input logic [DW-1:0] d);
      bit accepted;
      @(negedge clk);
      start    = s;
      in_valid = v;
      in_data  = d;
      accepted = v && (ph == PH_LOAD || ph == PH_CHECK);
      exp_we   = 0;
      case (ph)
         PH_IDLE, PH_RUN, PH_ERR: begin
            if (s) begin
               ph    = PH_LOAD;
               m_cnt = 0;
               m_sum = 0;
            end
         end
         PH_LOAD: begin
            if (accepted) begin
               exp_we   = 1;
               exp_addr = m_cnt;
               exp_data = int'(d);
               m_sum    = (m_sum + int'(d)) % MODV;
               m_cnt    = m_cnt + 1;
               if (m_cnt == DEPTH) ph = PH_CHECK;
            end
         end
         PH_CHECK: begin
            if (accepted) ph = (((m_sum + int'(d)) % MODV) == 0) ? PH_RUN : PH_ERR;
         end
         default: ph = PH_IDLE;
      endcase
      @(posedge clk);
      #1;
      checkAll();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      ph       = PH_IDLE;
      m_cnt    = 0;
      m_sum    = 0;
      exp_we   = 0;
      exp_addr = 0;
      exp_data = 0;
      checkAll();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [DW-1:0] goodChecksum();
      int s;
      s = 0;
      for (int i = 0; i < DEPTH; i++) s = s + int'(words[i]);
      return DW'((MODV - (s % MODV)) % MODV);
   endfunction

   task automatic idleGap(input bit noise);
      while ($urandom_range(0, 2) == 0)
         applyStimulus(noise && ($urandom_range(0, 3) == 0), 1'b0, DW'($urandom));
   endtask

   task automatic sendStream(input bit gaps, input bit noise, input logic [DW-1:0] chk);
      for (int i = 0; i < DEPTH; i++) begin
         if (gaps) idleGap(noise);
         applyStimulus(noise && ($urandom_range(0, 3) == 0), 1'b1, words[i]);
      end
      if (gaps) idleGap(noise);
      applyStimulus(1'b0, 1'b1, chk);
   endtask

   task automatic checkSram();
      for (int i = 0; i < DEPTH; i++)
         checkOutput($sformatf("sram[%0d]", i), 32'(sram[i]), 32'(words[i]));
   endtask

   task automatic loadFixedWords();
      logic [DW-1:0] fixed [DEPTH];
      fixed = '{9'h009, 9'h02A, 9'h04B, 9'h060, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF,
                9'h1FF, 9'h001, 9'h002, 9'h001, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
      for (int i = 0; i < DEPTH; i++) words[i] = fixed[i];
   endtask

   initial begin
      logic [DW-1:0] chk;
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      doReset();

      // In IDLE a valid word must be ignored entirely.
      repeat (3) applyStimulus(1'b0, 1'b1, DW'($urandom));

      loadFixedWords();
      chk = goodChecksum();
      checkOutput("fixed_checksum", 32'(chk), 32'h127);
      applyStimulus(1'b1, 1'b0, '0);
      sendStream(1'b0, 1'b0, chk);
      repeat (3) applyStimulus(1'b0, 1'b1, DW'($urandom));
      checkSram();

      applyStimulus(1'b1, 1'b0, '0);
      sendStream(1'b0, 1'b0, chk + 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b1, DW'($urandom));
      checkSram();

      applyStimulus(1'b1, 1'b0, '0);
      sendStream(1'b1, 1'b1, chk);
      applyStimulus(1'b0, 1'b0, '0);
      checkSram();

      applyStimulus(1'b1, 1'b0, '0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, words[i]);
      doReset();
      applyStimulus(1'b1, 1'b0, '0);
      sendStream(1'b1, 1'b0, chk);
      applyStimulus(1'b0, 1'b0, '0);
      checkSram();

      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < DEPTH; i++) words[i] = DW'($urandom);
         chk = goodChecksum();
         if ($urandom_range(0, 1) == 1) chk = chk + DW'($urandom_range(1, MODV - 1));
         applyStimulus(1'b1, 1'b0, '0);
         sendStream(1'b1, 1'b1, chk);
         repeat (2) applyStimulus(1'b0, 1'b1, DW'($urandom));
         checkSram();
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
